cds_pll_lock_mgr: RTL and testbench

Multi-channel PLL reset and lock supervisor for the cold-data-stream clocking tree. It drives the reset input of up to N_PLL vendor PLL wrappers and synchronises their asynchronous `locked` outputs. Each lock is debounced, and per-channel and aggregate ready flags are raised only after a stable settle interval. Lock timeouts are retried automatically, a channel faults after a bounded number of retries, and losses of lock can optionally be counted.

---
 rtl/cds_pll_pkg.sv | 28 ++
 rtl/cds_pll_lock_mgr_if.sv | 32 +++
 rtl/cds_pll_lock_chan.sv | 137 +++++++++++++
 rtl/cds_pll_lock_mgr.sv | 47 ++++
 tb/tb_cds_pll_lock_mgr.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cds_pll_pkg.sv
// Shared types and constants for the cds_pll_lock_mgr PLL supervisor.
// The loss-of-lock counters are enabled by defining CDS_PLL_LOSS_CNT_EN.
package cds_pll_pkg;

    localparam int SYNC_DEPTH  = 2;
    localparam int DBG_RETRY_W = 8;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        SETTLE,
        READY,
        FAULT
    } pll_state_t;

    // Per-channel observation point: FSM state and zero-extended retry count.
    typedef struct packed {
        pll_state_t             state;
        logic [DBG_RETRY_W-1:0] retry;
    } chan_dbg_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cds_pll_lock_mgr_if.sv
// Bundle between the PLL supervisor and its surroundings (PLL wrappers and
// control). The supervisor side uses the slave modport.
interface cds_pll_lock_mgr_if #(
    parameter int N_PLL = 4,
    parameter int CNT_W = 8
);
    import cds_pll_pkg::*;

    // No valid/ready handshake: pll_locked is asynchronous, force_rst is
    // level-sampled every cycle, retry_clr is a one-cycle pulse; every
    // output is a registered status level.
    logic [N_PLL-1:0]       pll_locked;
    logic [N_PLL-1:0]       force_rst;
    logic                   retry_clr;
    logic [N_PLL-1:0]       pll_rst;
    logic [N_PLL-1:0]       chan_ready;
    logic                   all_ready;
    logic [N_PLL-1:0]       fault;
    logic [N_PLL*CNT_W-1:0] loss_cnt;
    chan_dbg_t [N_PLL-1:0]  dbg;

    modport master (
        output pll_locked, force_rst, retry_clr,
        input  pll_rst, chan_ready, all_ready, fault, loss_cnt, dbg
    );

    modport slave (
        input  pll_locked, force_rst, retry_clr,
        output pll_rst, chan_ready, all_ready, fault, loss_cnt, dbg
    );

endinterface

// File: rtl/cds_pll_lock_chan.sv
// One supervised PLL: lock synchroniser, reset/lock FSM, shared timer, retry
// counter and (with CDS_PLL_LOSS_CNT_EN) a saturating loss-of-lock counter.
module cds_pll_lock_chan
    import cds_pll_pkg::*;
#(
    parameter int RST_CYC      = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int SETTLE_CYC   = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             force_rst,
    input  logic             retry_clr,
    output logic             pll_rst,
    output logic             chan_ready,
    output logic             fault,
    output logic [CNT_W-1:0] loss_cnt,
    output chan_dbg_t        dbg
);
    localparam int TW = $clog2(max3(RST_CYC, LOCK_TIMEOUT, SETTLE_CYC)) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  locked_s;
    pll_state_t            state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [RW-1:0]         retry, retry_n, retry_inc;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_DEPTH-2:0], pll_locked};
    end
    assign locked_s  = sync_q[SYNC_DEPTH-1];
    assign retry_inc = retry + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET;
            timer <= '0;
            retry <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            retry <= retry_n;
        end
    end

    // A restart request overrides everything, including a same-cycle lock loss.
    always_comb begin
        state_n = state;
        timer_n = timer;
        retry_n = retry;
        if (force_rst) begin
            state_n = RESET;
            timer_n = '0;
            retry_n = '0;
        end else begin
            case (state)
                RESET: begin
                    if (timer == TW'(RST_CYC - 1)) begin
                        state_n = WAIT_LOCK;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_n = SETTLE;
                        timer_n = '0;
                    end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                        retry_n = retry_inc;
                        timer_n = '0;
                        state_n = (retry_inc == RW'(MAX_RETRY)) ? FAULT : RESET;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        state_n = WAIT_LOCK;
                        timer_n = '0;
                    end else if (timer == TW'(SETTLE_CYC - 1)) begin
                        state_n = READY;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                READY: begin
                    retry_n = '0;
                    if (!locked_s) begin
                        state_n = RESET;
                        timer_n = '0;
                    end
                end
                FAULT: begin
                    if (retry_clr) begin
                        state_n = RESET;
                        timer_n = '0;
                        retry_n = '0;
                    end
                end
                default: begin
                    state_n = RESET;
                    timer_n = '0;
                    retry_n = '0;
                end
            endcase
        end
    end

    assign pll_rst    = (state == RESET) || (state == FAULT);
    assign chan_ready = (state == READY);
    assign fault      = (state == FAULT);
    assign dbg.state  = state;
    assign dbg.retry  = DBG_RETRY_W'(retry);

`ifdef CDS_PLL_LOSS_CNT_EN
    logic             loss_inc;
    logic [CNT_W-1:0] loss_q;

    assign loss_inc = (state == READY) && !locked_s && !force_rst;

    always_ff @(posedge clk) begin
        if (rst)                             loss_q <= '0;
        else if (loss_inc && (loss_q != '1)) loss_q <= loss_q + 1'b1;
    end
    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: rtl/cds_pll_lock_mgr.sv
// Multi-channel PLL reset/lock supervisor: N_PLL channel instances plus the
// registered aggregate ready flag. Loss counters need CDS_PLL_LOSS_CNT_EN.
module cds_pll_lock_mgr
    import cds_pll_pkg::*;
#(
    parameter int N_PLL        = 4,
    parameter int RST_CYC      = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int SETTLE_CYC   = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 8
) (
    input  logic               refclk,
    input  logic               rst,
    cds_pll_lock_mgr_if.slave  bus
);
    logic [N_PLL-1:0] ready_w;

    for (genvar i = 0; i < N_PLL; i++) begin : g_chan
        cds_pll_lock_chan #(
            .RST_CYC      (RST_CYC),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .SETTLE_CYC   (SETTLE_CYC),
            .MAX_RETRY    (MAX_RETRY),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk        (refclk),
            .rst        (rst),
            .pll_locked (bus.pll_locked[i]),
            .force_rst  (bus.force_rst[i]),
            .retry_clr  (bus.retry_clr),
            .pll_rst    (bus.pll_rst[i]),
            .chan_ready (ready_w[i]),
            .fault      (bus.fault[i]),
            .loss_cnt   (bus.loss_cnt[i*CNT_W +: CNT_W]),
            .dbg        (bus.dbg[i])
        );
    end

    assign bus.chan_ready = ready_w;

    always_ff @(posedge refclk) begin
        if (rst) bus.all_ready <= 1'b0;
        else     bus.all_ready <= &ready_w;
    end

endmodule

// File: tb/tb_cds_pll_lock_mgr.sv
// Bench for cds_pll_lock_mgr: timing table and corner sequences on a default
// instance, fault/retry sequence and randomized model check on a fast instance.
module tb_cds_pll_lock_mgr;
    import cds_pll_pkg::*;

    localparam int N    = 4;
    localparam int A_CW = 8;
    localparam int B_RST = 16, B_TO = 100, B_SET = 20, B_RETRY = 3, B_CW = 2;
    localparam int LOSS_MAX = (1 << B_CW) - 1;
`ifdef CDS_PLL_LOSS_CNT_EN
    localparam bit LOSS_ON = 1'b1;
`else
    localparam bit LOSS_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    cds_pll_lock_mgr_if #(.N_PLL(N), .CNT_W(A_CW)) ba ();
    cds_pll_lock_mgr_if #(.N_PLL(N), .CNT_W(B_CW)) bb ();

    cds_pll_lock_mgr #(.N_PLL(N), .RST_CYC(16), .LOCK_TIMEOUT(65535), .SETTLE_CYC(1024),
                       .MAX_RETRY(3), .CNT_W(A_CW))
        dut_a (.refclk(clk), .rst(rst_a), .bus(ba.slave));

    cds_pll_lock_mgr #(.N_PLL(N), .RST_CYC(B_RST), .LOCK_TIMEOUT(B_TO), .SETTLE_CYC(B_SET),
                       .MAX_RETRY(B_RETRY), .CNT_W(B_CW))
        dut_b (.refclk(clk), .rst(rst_b), .bus(bb.slave));

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: sim time %0t exceeded limit %0d", $time, 5_000_000);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_a(input logic [N-1:0] lock);
        ba.pll_locked = lock;
        ba.force_rst  = '0;
        ba.retry_clr  = 1'b0;
        rst_a = 1'b1;
        tick(3);
        rst_a = 1'b0;
    endtask

    task automatic wait_ready_a(input int limit);
        int k = 0;
        while (!ba.all_ready && k < limit) begin
            tick(1);
            k++;
        end
        check("a_ready_bound", ba.all_ready, 1);
    endtask

    // ---------------- reference model (fast instance) ----------------
    localparam int PH_RST = 0, PH_WAIT = 1, PH_SET = 2, PH_RDY = 3, PH_FLT = 4;
    int             m_ph[N], m_age[N], m_tries[N], m_loss[N];
    bit             m_all;
    logic [N-1:0]   m_sync[$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ph[i] = PH_RST; m_age[i] = 0; m_tries[i] = 0; m_loss[i] = 0;
        end
        m_all = 1'b0;
        m_sync.delete();
        m_sync.push_back('0);
        m_sync.push_back('0);
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input bit r, input logic [N-1:0] lk, input logic [N-1:0] fr,
                              input bit clr);
        logic [N-1:0] ls;
        bit all_n;
        if (r) begin
            model_reset();
            return;
        end
        all_n = 1'b1;
        for (int i = 0; i < N; i++) if (m_ph[i] != PH_RDY) all_n = 1'b0;
        ls = m_sync.pop_front();
        m_sync.push_back(lk);
        for (int i = 0; i < N; i++) begin
            if (fr[i]) begin
                m_ph[i] = PH_RST; m_age[i] = 0; m_tries[i] = 0;
            end else begin
                case (m_ph[i])
                    PH_RST: begin
                        m_age[i]++;
                        if (m_age[i] == B_RST) begin m_ph[i] = PH_WAIT; m_age[i] = 0; end
                    end
                    PH_WAIT: begin
                        if (ls[i]) begin
                            m_ph[i] = PH_SET; m_age[i] = 0;
                        end else begin
                            m_age[i]++;
                            if (m_age[i] == B_TO) begin
                                m_tries[i]++;
                                m_age[i] = 0;
                                m_ph[i] = (m_tries[i] == B_RETRY) ? PH_FLT : PH_RST;
                            end
                        end
                    end
                    PH_SET: begin
                        if (!ls[i]) begin
                            m_ph[i] = PH_WAIT; m_age[i] = 0;
                        end else begin
                            m_age[i]++;
                            if (m_age[i] == B_SET) m_ph[i] = PH_RDY;
                        end
                    end
                    PH_RDY: begin
                        m_tries[i] = 0;
                        if (!ls[i]) begin
                            m_ph[i] = PH_RST; m_age[i] = 0;
                            if (m_loss[i] < LOSS_MAX) m_loss[i]++;
                        end
                    end
                    default: begin
                        if (clr) begin m_ph[i] = PH_RST; m_age[i] = 0; m_tries[i] = 0; end
                    end
                endcase
            end
        end
        m_all = all_n;
    endtask

    function automatic logic [20:0] model_out();
        logic [N-1:0]      pr, rd, fl;
        logic [N*B_CW-1:0] lc;
        pr = '0; rd = '0; fl = '0; lc = '0;
        for (int i = 0; i < N; i++) begin
            pr[i] = (m_ph[i] == PH_RST) || (m_ph[i] == PH_FLT);
            rd[i] = (m_ph[i] == PH_RDY);
            fl[i] = (m_ph[i] == PH_FLT);
            if (LOSS_ON) lc[i*B_CW +: B_CW] = B_CW'(m_loss[i]);
        end
        return {pr, rd, fl, m_all, lc};
    endfunction

    // ---------------- timing table ----------------
    typedef struct {
        int           cyc;
        bit           rst_next;
        logic [N-1:0] pll_rst;
        logic [N-1:0] ready;
        bit           all;
        logic [N-1:0] fault;
    } vec_t;

    vec_t tbl[12];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    initial begin
        int cyc;
        int run;
        int fault_cyc;
        bit seen;
        logic [N-1:0] lk_cur;
        logic [N-1:0] fr;
        bit r, clr;

        tbl[0]  = '{0,    0, 4'hF, 4'h0, 0, 4'h0};
        tbl[1]  = '{15,   0, 4'hF, 4'h0, 0, 4'h0};
        tbl[2]  = '{16,   0, 4'h0, 4'h0, 0, 4'h0};
        tbl[3]  = '{17,   0, 4'h0, 4'h0, 0, 4'h0};
        tbl[4]  = '{1040, 0, 4'h0, 4'h0, 0, 4'h0};
        tbl[5]  = '{1041, 0, 4'h0, 4'hF, 0, 4'h0};
        tbl[6]  = '{1042, 0, 4'h0, 4'hF, 1, 4'h0};
        tbl[7]  = '{1100, 1, 4'h0, 4'hF, 1, 4'h0};
        tbl[8]  = '{1101, 0, 4'hF, 4'h0, 0, 4'h0};
        tbl[9]  = '{1102, 0, 4'hF, 4'h0, 0, 4'h0};
        tbl[10] = '{1116, 0, 4'hF, 4'h0, 0, 4'h0};
        tbl[11] = '{1117, 0, 4'h0, 4'h0, 0, 4'h0};

        bb.pll_locked = '0; bb.force_rst = '0; bb.retry_clr = 1'b0;

        // Startup timing and mid-run reset on the default instance.
        reset_a(4'hF);
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            while (cyc < tbl[i].cyc) begin tick(1); cyc++; end
            check($sformatf("tbl%0d_pll_rst", i), ba.pll_rst,    tbl[i].pll_rst);
            check($sformatf("tbl%0d_ready", i),   ba.chan_ready, tbl[i].ready);
            check($sformatf("tbl%0d_all", i),     ba.all_ready,  tbl[i].all);
            check($sformatf("tbl%0d_fault", i),   ba.fault,      tbl[i].fault);
            check($sformatf("tbl%0d_loss", i),    ba.loss_cnt,   32'h0);
            rst_a = tbl[i].rst_next;
        end

        // Single-cycle lock drop on channel 0 while READY.
        reset_a(4'hF);
        wait_ready_a(1200);
        ba.pll_locked[0] = 1'b0;
        tick(1);
        ba.pll_locked[0] = 1'b1;
        check("drop_hold1", ba.chan_ready, 4'hF);
        tick(1);
        check("drop_hold2", ba.chan_ready, 4'hF);
        tick(1);
        check("drop_ready", ba.chan_ready, 4'hE);
        check("drop_pll_rst", ba.pll_rst, 4'h1);
        check("drop_loss0", ba.loss_cnt[7:0], LOSS_ON ? 8'd1 : 8'd0);
        check("drop_loss_others", ba.loss_cnt[31:8], 24'h0);
        tick(1);
        check("drop_all", ba.all_ready, 0);
        tick(14);
        check("drop_rst_hold", ba.pll_rst[0], 1);
        tick(1);
        check("drop_rst_release", ba.pll_rst[0], 0);

        // Channel 1 toggles lock every 500 cycles: never long enough to settle.
        reset_a(4'b1101);
        tick(20);
        seen = 1'b0;
        for (int t = 0; t < 4; t++) begin
            ba.pll_locked[1] = (t % 2 == 0);
            for (int k = 0; k < 500; k++) begin
                tick(1);
                if (ba.chan_ready[1]) seen = 1'b1;
            end
        end
        check("toggle_never_ready", seen, 0);
        check("toggle_retry", ba.dbg[1].retry, 0);
        check("toggle_state", ba.dbg[1].state, WAIT_LOCK);
        check("toggle_others", ba.chan_ready, 4'b1101);

        // Force and lock loss reach channel 3 on the same edge.
        reset_a(4'hF);
        wait_ready_a(1200);
        ba.pll_locked[3] = 1'b0;
        tick(2);
        ba.force_rst[3] = 1'b1;
        tick(1);
        ba.force_rst[3] = 1'b0;
        ba.pll_locked[3] = 1'b1;
        check("force_state", ba.dbg[3].state, RESET);
        check("force_pll_rst", ba.pll_rst, 4'h8);
        check("force_ready", ba.chan_ready, 4'h7);
        tick(3);
        check("force_loss3", ba.loss_cnt[31:24], 8'd0);
        check("force_retry3", ba.dbg[3].retry, 0);
        rst_a = 1'b1;

        // Channel 2 never locks on the fast instance: retries, then FAULT.
        bb.pll_locked = 4'b1011;
        rst_b = 1'b1;
        tick(3);
        rst_b = 1'b0;
        exp_q = {16'(B_RST), 16'(B_RST), 16'(B_RST)};
        got_q.delete();
        run = 0;
        fault_cyc = -1;
        for (int c = 0; c < 400; c++) begin
            if (bb.fault[2] && fault_cyc < 0) fault_cyc = c;
            if (fault_cyc < 0) begin
                if (bb.pll_rst[2]) run++;
                else if (run > 0) begin got_q.push_back(16'(run)); run = 0; end
            end
            tick(1);
        end
        check("retry_pulse_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("retry_pulse_len", got_q.pop_front(), exp_q.pop_front());
        check("retry_fault_cycle", fault_cyc, 3 * (B_RST + B_TO));
        check("retry_fault", bb.fault, 4'b0100);
        check("retry_pll_rst", bb.pll_rst, 4'b0100);
        check("retry_ready", bb.chan_ready, 4'b1011);
        bb.retry_clr = 1'b1;
        tick(1);
        bb.retry_clr = 1'b0;
        check("clr_state", bb.dbg[2].state, RESET);
        check("clr_fault", bb.fault, 4'b0000);
        check("clr_pll_rst", bb.pll_rst[2], 1);
        check("clr_retry", bb.dbg[2].retry, 0);

        // Randomized run against the reference model.
        rst_b = 1'b1;
        bb.pll_locked = '0; bb.force_rst = '0; bb.retry_clr = 1'b0;
        lk_cur = '0;
        model_reset();
        tick(1);
        for (int c = 0; c < 6000; c++) begin
            check("rand", {bb.pll_rst, bb.chan_ready, bb.fault, bb.all_ready, bb.loss_cnt},
                  model_out());
            r = ($urandom_range(0, 799) == 0);
            for (int i = 0; i < N; i++) begin
                if (lk_cur[i]) begin
                    if ($urandom_range(0, 59) == 0) lk_cur[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 149) == 0) lk_cur[i] = 1'b1;
                end
                fr[i] = ($urandom_range(0, 399) == 0);
            end
            clr = ($urandom_range(0, 149) == 0);
            rst_b = r;
            bb.pll_locked = lk_cur;
            bb.force_rst = fr;
            bb.retry_clr = clr;
            model_step(r, lk_cur, fr, clr);
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
